// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel window front end.
package sobel_pkg;

  localparam int NBIT           = 8;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int COL_W          = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_W          = $clog2(DEF_IMG_HEIGHT);

  typedef logic [NBIT-1:0] pixel_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of storage: combinational read of the old word, write on the clock edge.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int depth = DEF_IMG_WIDTH,
  parameter int width = NBIT
) (
  input  logic                     clk,
  input  logic [$clog2(depth)-1:0] addr,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  output logic [width-1:0]         rd_data
);

  logic [width-1:0] mem_r [depth];

  // Read returns the word stored before this cycle's write lands.
  assign rd_data = mem_r[addr];

  // Row storage update; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_3x3.sv
// Raster-stream to registered 3x3 neighbourhood for interior pixels, with centre coordinates.
module sobel_window_3x3
  import sobel_pkg::*;
#(
  parameter int nbit       = NBIT,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [nbit-1:0]               in_data,
  input  logic                          in_sof,
  output logic [nbit-1:0]               P0,
  output logic [nbit-1:0]               P1,
  output logic [nbit-1:0]               P2,
  output logic [nbit-1:0]               P3,
  output logic [nbit-1:0]               P4,
  output logic [nbit-1:0]               P5,
  output logic [nbit-1:0]               P6,
  output logic [nbit-1:0]               P7,
  output logic [nbit-1:0]               P8,
  output logic                          win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]   col_r;
  logic [RW-1:0]   row_r;
  logic [nbit-1:0] win_r [9];
  logic            win_valid_r;
  logic [RW-1:0]   win_row_r;
  logic [CW-1:0]   win_col_r;
  logic            frame_done_r;

  logic            sof_s;
  logic [CW-1:0]   cur_col_s;
  logic [RW-1:0]   cur_row_s;
  logic [CW-1:0]   next_col_s;
  logic [RW-1:0]   next_row_s;
  logic            last_col_s;
  logic            last_row_s;
  logic            interior_s;
  logic [nbit-1:0] lb0_rd_s;
  logic [nbit-1:0] lb1_rd_s;

  // A start-of-frame pixel overrides the counters and is taken as (0,0).
  always_comb begin
    sof_s      = in_valid & in_sof;
    cur_col_s  = col_r;
    cur_row_s  = row_r;
    if (sof_s) begin
      cur_col_s = {CW{1'b0}};
      cur_row_s = {RW{1'b0}};
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
    last_col_s = (cur_col_s == CW'(IMG_WIDTH - 1));
    last_row_s = (cur_row_s == RW'(IMG_HEIGHT - 1));
    next_col_s = cur_col_s + CW'(1);
    next_row_s = cur_row_s;
    if (last_col_s) begin
      next_col_s = {CW{1'b0}};
      if (last_row_s) begin
        next_row_s = {RW{1'b0}};
      end else begin
        next_row_s = cur_row_s + RW'(1);
      end
    end else begin
      next_col_s = cur_col_s + CW'(1);
      next_row_s = cur_row_s;
    end
    interior_s = (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
  end

  // lb0 carries the previous row, lb1 the row before; lb1 is refilled from lb0's old word.
  sobel_line_buffer #(
    .depth (IMG_WIDTH),
    .width (nbit)
  ) u_lb0 (
    .clk     (clk),
    .addr    (cur_col_s),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_data (lb0_rd_s)
  );

  sobel_line_buffer #(
    .depth (IMG_WIDTH),
    .width (nbit)
  ) u_lb1 (
    .clk     (clk),
    .addr    (cur_col_s),
    .wr_en   (in_valid),
    .wr_data (lb0_rd_s),
    .rd_data (lb1_rd_s)
  );

  // Counters, window shift and strobes; everything holds while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r        <= {CW{1'b0}};
      row_r        <= {RW{1'b0}};
      win_valid_r  <= 1'b0;
      win_row_r    <= {RW{1'b0}};
      win_col_r    <= {CW{1'b0}};
      frame_done_r <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_r[i] <= {nbit{1'b0}};
      end
    end else begin
      win_valid_r  <= in_valid & interior_s;
      frame_done_r <= in_valid & last_col_s & last_row_s;
      if (in_valid) begin
        col_r    <= next_col_s;
        row_r    <= next_row_s;
        win_r[0] <= win_r[1];
        win_r[1] <= win_r[2];
        win_r[2] <= lb1_rd_s;
        win_r[3] <= win_r[4];
        win_r[4] <= win_r[5];
        win_r[5] <= lb0_rd_s;
        win_r[6] <= win_r[7];
        win_r[7] <= win_r[8];
        win_r[8] <= in_data;
        if (interior_s) begin
          win_row_r <= cur_row_s - RW'(1);
          win_col_r <= cur_col_s - CW'(1);
        end else begin
          win_row_r <= win_row_r;
          win_col_r <= win_col_r;
        end
      end else begin
        col_r <= col_r;
        row_r <= row_r;
      end
    end
  end

  assign P0         = win_r[0];
  assign P1         = win_r[1];
  assign P2         = win_r[2];
  assign P3         = win_r[3];
  assign P4         = win_r[4];
  assign P5         = win_r[5];
  assign P6         = win_r[6];
  assign P7         = win_r[7];
  assign P8         = win_r[8];
  assign win_valid  = win_valid_r;
  assign win_row    = win_row_r;
  assign win_col    = win_col_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Scoreboard bench for sobel_window_3x3 on a 4x4 image with pixel = base + 16*r + c.
module tb_sobel_window_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;
  logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
  logic       win_valid;
  logic [1:0] win_row;
  logic [1:0] win_col;
  logic       frame_done;

  sobel_window_3x3 #(.nbit(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         valid;
    bit         done;
    logic [71:0] win;
    logic [1:0] row;
    logic [1:0] col;
  } rec_t;

  typedef struct {
    logic [71:0] win;
    logic [1:0]  row;
    logic [1:0]  col;
  } obs_t;

  rec_t exp_q[$];
  obs_t obs_q[$];
  obs_t ref_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   done_cnt  = 0;
  int   m_row = 0;
  int   m_col = 0;
  logic [7:0] img [H][W];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle at the falling edge and record what the model expects one edge later.
  task automatic drive(input bit v, input logic [7:0] d, input bit sof);
    rec_t r;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_sof   = sof;
    r.valid = 1'b0; r.done = 1'b0; r.win = 72'h0; r.row = 2'd0; r.col = 2'd0;
    if (v) begin
      if (sof) begin
        m_row = 0;
        m_col = 0;
      end
      img[m_row][m_col] = d;
      if (m_row >= 2 && m_col >= 2) begin
        r.valid = 1'b1;
        r.win = {img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col],
                 img[m_row-1][m_col-2], img[m_row-1][m_col-1], img[m_row-1][m_col],
                 img[m_row][m_col-2],   img[m_row][m_col-1],   img[m_row][m_col]};
        r.row = 2'(m_row - 1);
        r.col = 2'(m_col - 1);
      end
      r.done = (m_row == H-1) && (m_col == W-1);
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
    exp_q.push_back(r);
  endtask

  task automatic send_frame(input logic [7:0] base, input bit sof, input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) drive(1'b0, 8'hEE, 1'b1);
      end
      drive(1'b1, base + 8'(16 * (i / W) + (i % W)), sof && (i == 0));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  // Compare every cycle's outputs against the oldest queued expectation.
  always @(posedge clk) begin
    rec_t r;
    obs_t o;
    #1;
    o.win = {P0, P1, P2, P3, P4, P5, P6, P7, P8};
    o.row = win_row;
    o.col = win_col;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("win_valid", {71'h0, win_valid}, {71'h0, r.valid});
      chk("frame_done", {71'h0, frame_done}, {71'h0, r.done});
      if (r.valid) begin
        chk("window", o.win, r.win);
        chk("win_row", {70'h0, win_row}, {70'h0, r.row});
        chk("win_col", {70'h0, win_col}, {70'h0, r.col});
      end
    end else begin
      chk("idle_valid", {71'h0, win_valid}, 72'h0);
      chk("idle_done", {71'h0, frame_done}, 72'h0);
    end
    if (win_valid) obs_q.push_back(o);
    if (frame_done) done_cnt++;
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sof = 1'b0;
    #1;
    chk("reset_win", {P0, P1, P2, P3, P4, P5, P6, P7, P8}, 72'h0);
    chk("reset_flags", {67'h0, win_valid, win_row, win_col}, 72'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame with sof on the first pixel.
    obs_q.delete(); done_cnt = 0;
    send_frame(8'h00, 1'b1, 1'b0, W * H);
    idle(2);
    chk("f1_count", 72'(obs_q.size()), 72'd4);
    chk("f1_first", obs_q[0].win, 72'h00_01_02_10_11_12_20_21_22);
    chk("f1_centres", {64'h0, obs_q[0].row, obs_q[0].col, obs_q[1].row, obs_q[1].col},
        {64'h0, 2'd1, 2'd1, 2'd1, 2'd2});
    chk("f1_last_centre", {68'h0, obs_q[3].row, obs_q[3].col}, {68'h0, 2'd2, 2'd2});
    chk("f1_done_cnt", 72'(done_cnt), 72'd1);
    ref_q = obs_q;

    // Same frame with random input gaps.
    obs_q.delete();
    send_frame(8'h00, 1'b1, 1'b1, W * H);
    idle(2);
    chk("gap_count", 72'(obs_q.size()), 72'd4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      chk("gap_window", obs_q[i].win, ref_q[i].win);
      chk("gap_centre", {68'h0, obs_q[i].row, obs_q[i].col}, {68'h0, ref_q[i].row, ref_q[i].col});
    end

    // Two frames back to back, no sof on the second.
    obs_q.delete(); done_cnt = 0;
    send_frame(8'h00, 1'b1, 1'b0, W * H);
    send_frame(8'h80, 1'b0, 1'b0, W * H);
    idle(2);
    chk("b2b_count", 72'(obs_q.size()), 72'd8);
    chk("b2b_p4", {64'h0, obs_q[4].win[39:32]}, 72'h91);
    chk("b2b_centre", {68'h0, obs_q[4].row, obs_q[4].col}, {68'h0, 2'd1, 2'd1});
    chk("b2b_done_cnt", 72'(done_cnt), 72'd2);

    // sof arrives at pixel (2,1) of a frame.
    obs_q.delete();
    send_frame(8'h00, 1'b1, 1'b0, 9);
    send_frame(8'h40, 1'b1, 1'b0, W * H);
    idle(2);
    chk("sof_count", 72'(obs_q.size()), 72'd4);
    chk("sof_first", obs_q[0].win, 72'h40_41_42_50_51_52_60_61_62);
    chk("sof_centre", {68'h0, obs_q[0].row, obs_q[0].col}, {68'h0, 2'd1, 2'd1});

    // Reset mid-frame after pixel (2,3).
    send_frame(8'h20, 1'b1, 1'b0, 12);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_mid_win", {P0, P1, P2, P3, P4, P5, P6, P7, P8}, 72'h0);
    chk("rst_mid_flags", {66'h0, win_valid, win_row, win_col, frame_done}, 72'h0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    send_frame(8'h00, 1'b0, 1'b0, W * H);
    idle(2);
    chk("rst_count", 72'(obs_q.size()), 72'd4);
    chk("rst_first", obs_q[0].win, 72'h00_01_02_10_11_12_20_21_22);
    chk("rst_centre", {68'h0, obs_q[0].row, obs_q[0].col}, {68'h0, 2'd1, 2'd1});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
